apb_modport: RTL and testbench

// - Self-contained APB subsystem: one APB master bridge plus two APB slave memories, all behind a simple transfer-request interface.
// - Testbench drives transfer/read_write/addresses/data and reads back apb_read_data_out.
// - Address MSB selects the slave; the lower bits index a byte-wide register file inside that slave.

---
 rtl/apb_modport_pkg.sv | 7 +
 rtl/apb_modport_if.sv | 22 ++
 rtl/apb_modport_slave.sv | 51 +++++
 rtl/apb_modport.sv | 120 ++++++++++++
 tb/tb_apb_modport.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/apb_modport_pkg.sv
// Shared constants and state type for the APB bridge subsystem.
package apb_pkg;
  localparam int unsigned AW_DEF = 9;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_modport_if.sv
// Transfer-request interface between a requester and the apb_modport subsystem.
interface apb_modport_if import apb_pkg::*; #(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;

  modport master (
    output transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    output apb_read_data_out
  );
endinterface

// File: rtl/apb_modport_slave.sv
// APB slave register file; APB_WAIT_EN adds one wait state to every access.
module apb_slave import apb_pkg::*; #(
  parameter int unsigned AW = AW_DEF - 1,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata_c,
  output logic          pready_c
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

`ifdef APB_WAIT_EN
  // Toggles high after the first ACCESS cycle so the second one completes.
  logic waited;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      waited <= 1'b0;
    end else if (psel && penable) begin
      waited <= !waited;
    end else begin
      waited <= 1'b0;
    end
  end

  assign pready_c = waited;
`else
  assign pready_c = 1'b1;
`endif

  // Commit only on the completing ACCESS cycle so a wait state cannot double-write.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (psel && penable && pwrite && pready_c) begin
      mem[paddr] <= pwdata;
    end
  end

  assign prdata_c = (psel && !pwrite) ? mem[paddr] : '0;
endmodule

// File: rtl/apb_modport.sv
// APB master bridge with two slave memories; address MSB picks the slave.
// Optional macro APB_WAIT_EN makes every slave insert one wait state.
module apb_modport import apb_pkg::*; #(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_modport_if.slave  bus
);
  apb_state_e    state_q, state_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          sel;
  logic [DW-1:0] prdata1_c, prdata2_c, prdata_c;
  logic          pready1_c, pready2_c, pready_c;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Bus signals are loaded on the edge entering SETUP and held until completion.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = !bus.read_write;
          paddr_d  = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;
          pwdata_d = bus.apb_write_data;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_c) begin
          penable_d = 1'b0;
          if (!pwrite_q) begin
            rdata_d = prdata_c;
          end
          if (bus.transfer) begin
            state_d  = SETUP;
            pwrite_d = !bus.read_write;
            paddr_d  = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;
            pwdata_d = bus.apb_write_data;
          end else begin
            state_d = IDLE;
            psel_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign sel      = paddr_q[AW-1];
  assign prdata_c = sel ? prdata2_c : prdata1_c;
  assign pready_c = sel ? pready2_c : pready1_c;

  assign bus.apb_read_data_out = rdata_q;

  apb_slave #(.AW(AW - 1), .DW(DW)) u_slave1 (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel_q && !sel),
    .penable  (penable_q),
    .pwrite   (pwrite_q),
    .paddr    (paddr_q[AW-2:0]),
    .pwdata   (pwdata_q),
    .prdata_c (prdata1_c),
    .pready_c (pready1_c)
  );

  apb_slave #(.AW(AW - 1), .DW(DW)) u_slave2 (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel_q && sel),
    .penable  (penable_q),
    .pwrite   (pwrite_q),
    .paddr    (paddr_q[AW-2:0]),
    .pwdata   (pwdata_q),
    .prdata_c (prdata2_c),
    .pready_c (pready2_c)
  );
endmodule

// File: tb/tb_apb_modport.sv
// Bench for apb_modport: directed table, reset and back-to-back sequences, random bursts.
module tb_apb_modport;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
`ifdef APB_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  logic pclk;
  logic presetn;
  apb_modport_if bus ();

  apb_modport dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vectors;
  int errors;

  logic [DW-1:0] mem_m [1 << AW];
  logic [DW-1:0] last_m;
  req_t          burst_q [$];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    last_m = '0;
  endtask

  // The address not used by this request carries junk to exercise the select.
  task automatic apply_req(input req_t r);
    bus.transfer        = 1'b1;
    bus.read_write      = r.rd;
    bus.apb_write_paddr = r.rd ? AW'($urandom) : r.addr;
    bus.apb_read_paddr  = r.rd ? r.addr : AW'($urandom);
    bus.apb_write_data  = r.rd ? DW'($urandom) : r.data;
  endtask

  task automatic scramble();
    bus.read_write      = 1'($urandom);
    bus.apb_write_paddr = AW'($urandom);
    bus.apb_read_paddr  = AW'($urandom);
    bus.apb_write_data  = DW'($urandom);
  endtask

  // Issues burst_q with transfer held high; each request completes LAT edges after it is sampled.
  task automatic run_burst();
    int n;
    req_t r;
    n = burst_q.size();
    @(negedge pclk);
    apply_req(burst_q[0]);
    @(posedge pclk);
    for (int i = 0; i < n; i++) begin
      #1;
      scramble();
      bus.transfer = (i + 1 < n);
      repeat (LAT - 1) @(posedge pclk);
      #1;
      check("hold_before_done", bus.apb_read_data_out, last_m);
      @(negedge pclk);
      if (i + 1 < n) apply_req(burst_q[i + 1]);
      @(posedge pclk);
      #1;
      r = burst_q[i];
      if (r.rd) last_m = mem_m[r.addr];
      else mem_m[r.addr] = r.data;
      check(r.rd ? "read_done" : "write_done", bus.apb_read_data_out, last_m);
    end
  endtask

  task automatic single(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    burst_q = {};
    burst_q.push_back('{rd: rd, addr: a, data: d});
    run_burst();
  endtask

  vec_t tbl [10];

  initial begin
    vectors = 0;
    errors  = 0;
    model_reset();

    tbl[0] = '{1'b1, 9'h005, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 9'h0A5, 8'h3C, 8'h00};
    tbl[2] = '{1'b1, 9'h0A5, 8'h00, 8'h3C};
    tbl[3] = '{1'b0, 9'h010, 8'h11, 8'h3C};
    tbl[4] = '{1'b0, 9'h110, 8'h22, 8'h3C};
    tbl[5] = '{1'b1, 9'h010, 8'h00, 8'h11};
    tbl[6] = '{1'b1, 9'h110, 8'h00, 8'h22};
    tbl[7] = '{1'b1, 9'h1FF, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 9'h1FF, 8'h5A, 8'h00};
    tbl[9] = '{1'b1, 9'h1FF, 8'h00, 8'h5A};

    presetn             = 1'b0;
    bus.transfer        = 1'b0;
    bus.read_write      = 1'b0;
    bus.apb_write_paddr = '0;
    bus.apb_read_paddr  = '0;
    bus.apb_write_data  = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_out", bus.apb_read_data_out, 8'h00);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    check("idle_out", bus.apb_read_data_out, 8'h00);

    for (int i = 0; i < 10; i++) begin
      single(tbl[i].rd, tbl[i].addr, tbl[i].data);
      check("table_vec", bus.apb_read_data_out, tbl[i].exp);
    end

    // Back-to-back writes then reads with transfer never dropped between them.
    burst_q = {};
    for (int i = 0; i < 4; i++) burst_q.push_back('{rd: 1'b0, addr: AW'(i), data: DW'(8'hA0 + i)});
    for (int i = 0; i < 4; i++) burst_q.push_back('{rd: 1'b1, addr: AW'(i), data: 8'h00});
    run_burst();
    check("b2b_last_read", bus.apb_read_data_out, 8'hA3);
    single(1'b1, 9'h001, 8'h00);
    check("b2b_read_1", bus.apb_read_data_out, 8'hA1);

    // Reset asserted while a write sits in SETUP: nothing commits and memories clear.
    @(negedge pclk);
    apply_req('{rd: 1'b0, addr: 9'h020, data: 8'hFF});
    @(posedge pclk);
    #1;
    presetn      = 1'b0;
    bus.transfer = 1'b0;
    #1;
    check("mid_reset_out", bus.apb_read_data_out, 8'h00);
    model_reset();
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    single(1'b1, 9'h020, 8'h00);
    check("mid_reset_no_commit", bus.apb_read_data_out, 8'h00);
    single(1'b1, 9'h010, 8'h00);
    check("mid_reset_mem_cleared", bus.apb_read_data_out, 8'h00);

    // Random bursts over a small address pool in both slaves to get read-after-write hits.
    for (int b = 0; b < 60; b++) begin
      int len;
      len = int'($urandom_range(1, 4));
      burst_q = {};
      for (int k = 0; k < len; k++) begin
        burst_q.push_back('{rd:   1'($urandom),
                            addr: {1'($urandom), 8'($urandom_range(0, 7))},
                            data: DW'($urandom)});
      end
      run_burst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
